// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the buffered 1-to-2 demultiplexer.
package cpu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } sel_e;

    // A full FIFO can still take a word when its head leaves on the same edge.
    function automatic logic can_accept(input logic full, input logic out_ready);
        return !full || out_ready;
    endfunction

endpackage

// File: rtl/demux1n2_buf_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; pure storage, no routing decisions.
module fifo2
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    // The head is read straight from storage, so it never goes X once reset.
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset here because the head is visible on the
            // output even while the FIFO is empty and must read as zero.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the
            // pre-edge values of the others regardless of statement order.
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux1n2_buf.sv
// Buffered 1-to-2 demultiplexer: each accepted word is queued in the FIFO picked by S.
module demux1n2_buf
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic             S,
    input  logic             HyrjaValid,
    output logic             HyrjaReady,
    output logic [WIDTH-1:0] Dalja0,
    output logic [WIDTH-1:0] Dalja1,
    output logic             Dalja0Valid,
    output logic             Dalja1Valid,
    input  logic             Dalja0Ready,
    input  logic             Dalja1Ready
);

    sel_e       sel;
    logic       accept;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] full;
    logic [1:0] valid;
    logic [1:0] out_ready;

    assign sel       = sel_e'(S);
    assign out_ready = {Dalja1Ready, Dalja0Ready};

    // Ready looks only at the selected FIFO: a blocked word stalls the input
    // even when the other side has room, so nothing overtakes it.
    assign HyrjaReady = can_accept(full[sel], out_ready[sel]);
    assign accept     = HyrjaValid && HyrjaReady;
    assign pop        = out_ready & valid;

    always_comb begin
        // NOTE: default first so every path assigns push and no latch appears.
        push = 2'b00;
        case (sel)
            SEL_OUT0: push[0] = accept;
            SEL_OUT1: push[1] = accept;
            default:  push    = 2'b00;
        endcase
    end

    fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (Clock),
        .rst_n (ResetN),
        .push  (push[0]),
        .pop   (pop[0]),
        .wdata (Hyrja),
        .rdata (Dalja0),
        .valid (valid[0]),
        .full  (full[0])
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (Clock),
        .rst_n (ResetN),
        .push  (push[1]),
        .pop   (pop[1]),
        .wdata (Hyrja),
        .rdata (Dalja1),
        .valid (valid[1]),
        .full  (full[1])
    );

    assign Dalja0Valid = valid[0];
    assign Dalja1Valid = valid[1];

endmodule

// File: tb/tb_demux1n2_buf.sv
// Scoreboard bench for demux1n2_buf: driver queues expected words, monitor checks outputs.
module tb_demux1n2_buf;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] hyrja;
    logic         s;
    logic         hyrja_valid;
    logic         hyrja_ready;
    logic [W-1:0] dalja0;
    logic [W-1:0] dalja1;
    logic         dalja0_valid;
    logic         dalja1_valid;
    logic         dalja0_ready;
    logic         dalja1_ready;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           n_checks = 0;
    int           n_errors = 0;

    demux1n2_buf #(.WIDTH(W)) dut (
        .Clock       (clk),
        .ResetN      (rst_n),
        .Hyrja       (hyrja),
        .S           (s),
        .HyrjaValid  (hyrja_valid),
        .HyrjaReady  (hyrja_ready),
        .Dalja0      (dalja0),
        .Dalja1      (dalja1),
        .Dalja0Valid (dalja0_valid),
        .Dalja1Valid (dalja1_valid),
        .Dalja0Ready (dalja0_ready),
        .Dalja1Ready (dalja1_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: transfers are decided by values stable between negedge and the next posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dalja0_valid && dalja0_ready) begin
                if (q0.size() == 0) check("out0_spurious", 32'(dalja0_valid), 32'd0);
                else                check("out0_data", 32'(dalja0), 32'(q0.pop_front()));
            end
            if (dalja1_valid && dalja1_ready) begin
                if (q1.size() == 0) check("out1_spurious", 32'(dalja1_valid), 32'd0);
                else                check("out1_data", 32'(dalja1), 32'(q1.pop_front()));
            end
        end
    end

    function automatic void expect_word(input logic sel, input logic [W-1:0] d);
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [W-1:0] d, input logic sel);
        bit done = 1'b0;
        int waited = 0;
        hyrja       = d;
        s           = sel;
        hyrja_valid = 1'b1;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (hyrja_ready) begin
                expect_word(sel, d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        if (!done) check("send_timeout", 32'(hyrja_ready), 32'd1);
        hyrja_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
        check({tag, "_q1_left"}, 32'(q1.size()), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        hyrja        = '0;
        s            = 1'b0;
        hyrja_valid  = 1'b0;
        dalja0_ready = 1'b0;
        dalja1_ready = 1'b0;
        idle(2);

        // Reset state
        check("rst_valid0", 32'(dalja0_valid), 32'd0);
        check("rst_valid1", 32'(dalja1_valid), 32'd0);
        check("rst_data0", 32'(dalja0), 32'd0);
        check("rst_data1", 32'(dalja1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(hyrja_ready), 32'd1);

        // Routing and one-cycle latency
        dalja0_ready = 1'b1;
        dalja1_ready = 1'b1;
        hyrja = 16'h1234; s = 1'b0; hyrja_valid = 1'b1;
        #1;
        check("no_comb_path", 32'(dalja0_valid), 32'd0);
        send(16'h1234, 1'b0);
        check("route0_valid", 32'(dalja0_valid), 32'd1);
        check("route0_data", 32'(dalja0), 32'h1234);
        send(16'hABCD, 1'b1);
        check("route1_valid", 32'(dalja1_valid), 32'd1);
        check("route1_data", 32'(dalja1), 32'hABCD);
        check("route0_popped", 32'(dalja0_valid), 32'd0);

        // Full / stall, then drain in order
        dalja0_ready = 1'b0;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        hyrja = 16'h0003; s = 1'b0; hyrja_valid = 1'b1;
        #1;
        check("stall_full0", 32'(hyrja_ready), 32'd0);
        @(negedge clk);
        check("stall_full0_hold", 32'(hyrja_ready), 32'd0);
        check("stall_head_stable", 32'(dalja0), 32'h0001);
        @(posedge clk);
        #1;
        dalja0_ready = 1'b1;
        #1;
        check("full0_with_pop", 32'(hyrja_ready), 32'd1);
        send(16'h0003, 1'b0);
        idle(4);
        check_drained("stall");

        // Head-of-line block: the S=1 side stays empty while an S=0 word waits
        dalja0_ready = 1'b0;
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        hyrja = 16'h0033; s = 1'b0; hyrja_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hol_ready", 32'(hyrja_ready), 32'd0);
            check("hol_fifo1_empty", 32'(dalja1_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        dalja0_ready = 1'b1;
        send(16'h0033, 1'b0);
        send(16'h0044, 1'b1);
        idle(4);
        check_drained("hol");

        // Full-with-pop on FIFO 1
        dalja1_ready = 1'b0;
        send(16'h00A1, 1'b1);
        send(16'h00A2, 1'b1);
        dalja1_ready = 1'b1;
        s = 1'b1;
        #1;
        check("full1_with_pop", 32'(hyrja_ready), 32'd1);
        send(16'h00FF, 1'b1);
        dalja1_ready = 1'b0;
        s = 1'b1;
        #1;
        check("count1_still_full", 32'(hyrja_ready), 32'd0);
        check("count1_head", 32'(dalja1), 32'h00A2);
        dalja1_ready = 1'b1;
        idle(4);
        check_drained("fwp");

        // Asynchronous reset mid-stream
        dalja0_ready = 1'b0;
        dalja1_ready = 1'b0;
        send(16'h00B0, 1'b0);
        send(16'h00B1, 1'b0);
        send(16'h00C0, 1'b1);
        send(16'h00C1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid0", 32'(dalja0_valid), 32'd0);
        check("arst_valid1", 32'(dalja1_valid), 32'd0);
        check("arst_data0", 32'(dalja0), 32'd0);
        check("arst_data1", 32'(dalja1), 32'd0);
        check("arst_ready", 32'(hyrja_ready), 32'd1);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        dalja0_ready = 1'b1;
        dalja1_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid0", 32'(dalja0_valid), 32'd0);
            check("post_rst_valid1", 32'(dalja1_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random soak against the per-output scoreboard
        for (int i = 0; i < 10000; i++) begin
            logic exp_ready;
            hyrja        = W'($urandom);
            s            = 1'($urandom_range(0, 1));
            hyrja_valid  = ($urandom_range(0, 99) < 70);
            dalja0_ready = ($urandom_range(0, 99) < 60);
            dalja1_ready = ($urandom_range(0, 99) < 60);
            #1;
            exp_ready = s ? (q1.size() < 2 || dalja1_ready) : (q0.size() < 2 || dalja0_ready);
            check("soak_ready", 32'(hyrja_ready), 32'(exp_ready));
            check("soak_valid0", 32'(dalja0_valid), 32'(q0.size() != 0));
            check("soak_valid1", 32'(dalja1_valid), 32'(q1.size() != 0));
            @(negedge clk);
            if (hyrja_valid && hyrja_ready) expect_word(s, hyrja);
            @(posedge clk);
            #1;
        end
        hyrja_valid  = 1'b0;
        dalja0_ready = 1'b1;
        dalja1_ready = 1'b1;
        idle(5);
        check_drained("soak");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
